nyq_filter: RTL and testbench

- Programmable Nyquist (pulse-shaping) FIR filter for the transmit/receive datapath.
- Accepts one signed sample per clock and produces one filtered sample per clock with one-cycle latency.
- Coefficients live in an internal register file written through a simple address/data/write-enable port.
- Coefficients are reloadable at any time; the filter never stalls.

---
 rtl/nyq_pkg.sv | 16 +
 rtl/nyq_coef_rf.sv | 24 ++
 rtl/nyq_filter.sv | 88 ++++++++
 tb/tb_nyq_filter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/nyq_pkg.sv
// Shared widths, derived sizes and saturation limits for the Nyquist FIR filter.
package nyq_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_MEM_WIDTH  = 24;
  localparam int unsigned DEF_IN_WIDTH   = 24;
  localparam int unsigned DEF_OUT_WIDTH  = 24;
  localparam int unsigned DEF_FRAC_BITS  = 22;

  localparam int unsigned DEF_NUM_TAPS  = 2 ** DEF_ADDR_WIDTH;
  localparam int unsigned DEF_ACC_WIDTH = DEF_MEM_WIDTH + DEF_IN_WIDTH + DEF_ADDR_WIDTH;

  localparam int SAT_MAX = (2 ** (DEF_OUT_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_OUT_WIDTH - 1));

endpackage

// File: rtl/nyq_coef_rf.sv
// Coefficient register file: async clear, one synchronous write port, all words visible.
module nyq_coef_rf #(
  parameter int unsigned ADDR_WIDTH = nyq_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH  = nyq_pkg::DEF_MEM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic signed [MEM_WIDTH-1:0] wr_data,
  output logic signed [MEM_WIDTH-1:0] coef [2**ADDR_WIDTH]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) begin
        coef[i] <= '0;
      end
    end else if (wr_en) begin
      coef[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/nyq_filter.sv
// Programmable 2**ADDR_WIDTH-tap Nyquist FIR: full-precision MAC, round-half-up, saturate, registered output.
module nyq_filter
  import nyq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic signed [MEM_WIDTH-1:0] PAR_In_DI,
  input  logic signed [IN_WIDTH-1:0]  NYQ_In_DI,
  output logic signed [OUT_WIDTH-1:0] NYQ_Out_DO
);

  localparam int unsigned NUM_TAPS   = 2 ** ADDR_WIDTH;
  localparam int unsigned PROD_WIDTH = MEM_WIDTH + IN_WIDTH;
  localparam int unsigned ACC_WIDTH  = PROD_WIDTH + ADDR_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = (ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -(ACC_WIDTH'(1) << (OUT_WIDTH - 1));

  logic signed [MEM_WIDTH-1:0]  coef   [NUM_TAPS];
  logic signed [IN_WIDTH-1:0]   dly    [1:NUM_TAPS-1];
  logic signed [IN_WIDTH-1:0]   tap_in [NUM_TAPS];
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  rnd_acc;
  logic signed [OUT_WIDTH-1:0]  sat;

  nyq_coef_rf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WIDTH  (MEM_WIDTH)
  ) u_coef_rf (
    .clk     (Clk_CI),
    .rst_n   (Rst_RBI),
    .wr_en   (WrEn_SI),
    .addr    (Addr_DI),
    .wr_data (PAR_In_DI),
    .coef    (coef)
  );

  always_comb begin
    tap_in[0] = NYQ_In_DI;
    for (int unsigned k = 1; k < NUM_TAPS; k++) begin
      tap_in[k] = dly[k];
    end
  end

  // Coefficients are read before the write edge, so a write only affects the next sum.
  always_comb begin
    prod = '0;
    acc  = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      prod = PROD_WIDTH'(coef[k]) * PROD_WIDTH'(tap_in[k]);
      acc  = acc + ACC_WIDTH'(prod);
    end
    rnd_acc = (acc + RND) >>> FRAC_BITS;
    if (rnd_acc > OUT_MAX) begin
      sat = OUT_MAX[OUT_WIDTH-1:0];
    end else if (rnd_acc < OUT_MIN) begin
      sat = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      sat = rnd_acc[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int unsigned k = 1; k < NUM_TAPS; k++) begin
        dly[k] <= '0;
      end
      NYQ_Out_DO <= '0;
    end else begin
      dly[1] <= NYQ_In_DI;
      for (int unsigned k = 2; k < NUM_TAPS; k++) begin
        dly[k] <= dly[k-1];
      end
      NYQ_Out_DO <= sat;
    end
  end

endmodule

// File: tb/tb_nyq_filter.sv
// Directed, table-driven bench for nyq_filter with hand-computed expected outputs.
module tb_nyq_filter;
  import nyq_pkg::*;

  logic               Clk_CI = 1'b0;
  logic               Rst_RBI;
  logic               WrEn_SI;
  logic [5:0]         Addr_DI;
  logic signed [23:0] PAR_In_DI;
  logic signed [23:0] NYQ_In_DI;
  logic signed [23:0] NYQ_Out_DO;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic               wr;
    logic [5:0]         addr;
    logic signed [23:0] par;
    logic signed [23:0] din;
    logic signed [23:0] dout;
  } vec_t;

  vec_t tbl[$];

  nyq_filter #(
    .ADDR_WIDTH (6),
    .MEM_WIDTH  (24),
    .IN_WIDTH   (24),
    .OUT_WIDTH  (24),
    .FRAC_BITS  (22)
  ) dut (
    .Clk_CI     (Clk_CI),
    .Rst_RBI    (Rst_RBI),
    .WrEn_SI    (WrEn_SI),
    .Addr_DI    (Addr_DI),
    .PAR_In_DI  (PAR_In_DI),
    .NYQ_In_DI  (NYQ_In_DI),
    .NYQ_Out_DO (NYQ_Out_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic check(input string name, input logic signed [23:0] act, input logic signed [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input int addr, input int par, input int din, input int dout);
    vec_t v;
    v.wr   = wr;
    v.addr = 6'(addr);
    v.par  = 24'(par);
    v.din  = 24'(din);
    v.dout = 24'(dout);
    tbl.push_back(v);
  endtask

  // Each row: inputs driven before an edge, expected output sampled 1 time unit after it.
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      WrEn_SI   = tbl[i].wr;
      Addr_DI   = tbl[i].addr;
      PAR_In_DI = tbl[i].par;
      NYQ_In_DI = tbl[i].din;
      @(posedge Clk_CI);
      #1;
      check($sformatf("%s_row%0d", tag, i), NYQ_Out_DO, tbl[i].dout);
    end
    WrEn_SI = 1'b0;
    tbl.delete();
  endtask

  initial begin
    Rst_RBI   = 1'b0;
    WrEn_SI   = 1'b1;
    Addr_DI   = 6'd0;
    PAR_In_DI = 24'sd4194304;
    NYQ_In_DI = 24'sd12345;
    #1;
    check("reset_async", NYQ_Out_DO, 24'sd0);
    repeat (2) @(posedge Clk_CI);
    #1;
    check("reset_hold", NYQ_Out_DO, 24'sd0);
    Rst_RBI = 1'b1;
    WrEn_SI = 1'b0;

    add(0, 0, 0,        1000,     0);
    add(0, 0, 0,        1000,     0);
    add(1, 0, 4194304,  1000,     0);
    add(0, 0, 0,        1000,     1000);
    add(0, 0, 0,        -1234,    -1234);
    add(1, 0, 0,        0,        0);
    add(1, 3, 2097152,  0,        0);
    add(0, 0, 0,        0,        -617);
    add(0, 0, 0,        0,        0);
    add(0, 0, 0,        1000,     0);
    add(0, 0, 0,        0,        0);
    add(0, 0, 0,        0,        0);
    add(0, 0, 0,        0,        500);
    add(0, 0, 0,        0,        0);
    add(1, 3, 0,        0,        0);
    add(1, 0, 1,        0,        0);
    add(0, 0, 0,        2097152,  1);
    add(0, 0, 0,        2097151,  0);
    add(0, 0, 0,        -2097152, 0);
    add(0, 0, 0,        -2097153, -1);
    add(1, 0, 8388607,  0,        0);
    add(0, 0, 0,        8388607,  SAT_MAX);
    add(0, 0, 0,        -8388608, SAT_MIN);
    add(1, 0, 4194304,  1000,     2000);
    add(0, 0, 0,        1000,     1000);
    add(1, 0, 0,        1000,     1000);
    add(0, 0, 0,        1000,     0);
    add(0, 0, 0,        1000,     0);
    add(1, 0, 4194304,  777,      0);
    add(0, 0, 0,        777,      777);
    add(0, 0, 0,        777,      777);
    run_table("main");

    #3;
    Rst_RBI = 1'b0;
    #1;
    check("midrst_async", NYQ_Out_DO, 24'sd0);
    @(posedge Clk_CI);
    #1;
    check("midrst_hold", NYQ_Out_DO, 24'sd0);
    Rst_RBI = 1'b1;

    add(0, 0, 0,        777, 0);
    add(1, 5, 4194304,  777, 0);
    add(0, 0, 0,        0,   0);
    add(0, 0, 0,        0,   0);
    add(0, 0, 0,        0,   0);
    add(0, 0, 0,        0,   777);
    add(0, 0, 0,        0,   777);
    add(0, 0, 0,        0,   0);
    run_table("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
